// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: operand forwarding, ALUSrc
// selection, load-use stall detection, flush squash and a bubble counter.
module id_ex_stage #(
    parameter int unsigned DW   = 32,
    parameter int unsigned AW   = 5,
    parameter int unsigned CNTW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [AW-1:0]   id_rs_addr,
    input  logic [AW-1:0]   id_rt_addr,
    input  logic            id_rs_used,
    input  logic            id_rt_used,
    input  logic [DW-1:0]   id_rs_data,
    input  logic [DW-1:0]   id_rt_data,
    input  logic [DW-1:0]   id_imm,
    input  logic [4:0]      id_shamt,
    input  logic            id_alusrc1,
    input  logic            id_alusrc2,
    input  logic [5:0]      id_alufun,
    input  logic            id_sign,
    input  logic            id_regwrite,
    input  logic            id_memread,
    input  logic            id_memwrite,
    input  logic            id_memtoreg,
    input  logic [AW-1:0]   id_wb_addr,
    input  logic [DW-1:0]   ex_fwd_data,
    input  logic            mem_regwrite,
    input  logic [AW-1:0]   mem_wb_addr,
    input  logic [DW-1:0]   mem_fwd_data,
    input  logic            wb_regwrite,
    input  logic [AW-1:0]   wb_wb_addr,
    input  logic [DW-1:0]   wb_fwd_data,
    input  logic            flush,
    output logic            stall_o,
    output logic            ex_valid,
    output logic [DW-1:0]   ex_alu_a,
    output logic [DW-1:0]   ex_alu_b,
    output logic [5:0]      ex_alufun,
    output logic            ex_sign,
    output logic [DW-1:0]   ex_store_data,
    output logic            ex_regwrite,
    output logic            ex_memread,
    output logic            ex_memwrite,
    output logic            ex_memtoreg,
    output logic [AW-1:0]   ex_wb_addr,
    output logic [CNTW-1:0] bubble_cnt
);

    logic          ex_fwd_ok;
    logic [DW-1:0] rs_fwd;
    logic [DW-1:0] rt_fwd;
    logic [DW-1:0] alu_a_c;
    logic [DW-1:0] alu_b_c;
    logic          bubble_c;

    // A load in EX has no result yet, so it cannot be forwarded from EX
    assign ex_fwd_ok = ex_valid & ex_regwrite & ~ex_memread;

    // rs operand: r0 is hardwired zero, then EX > MEM > WB > register file
    always_comb begin
        rs_fwd = id_rs_data;
        if (id_rs_addr == '0)
            rs_fwd = '0;
        else if (ex_fwd_ok && (ex_wb_addr == id_rs_addr))
            rs_fwd = ex_fwd_data;
        else if (mem_regwrite && (mem_wb_addr == id_rs_addr))
            rs_fwd = mem_fwd_data;
        else if (wb_regwrite && (wb_wb_addr == id_rs_addr))
            rs_fwd = wb_fwd_data;
    end

    // rt operand: same priority as rs
    always_comb begin
        rt_fwd = id_rt_data;
        if (id_rt_addr == '0)
            rt_fwd = '0;
        else if (ex_fwd_ok && (ex_wb_addr == id_rt_addr))
            rt_fwd = ex_fwd_data;
        else if (mem_regwrite && (mem_wb_addr == id_rt_addr))
            rt_fwd = mem_fwd_data;
        else if (wb_regwrite && (wb_wb_addr == id_rt_addr))
            rt_fwd = wb_fwd_data;
    end

    // ALU source muxes; shamt is zero-extended
    always_comb begin
        alu_a_c = id_alusrc1 ? DW'(id_shamt) : rs_fwd;
        alu_b_c = id_alusrc2 ? id_imm : rt_fwd;
    end

    // Load-use hazard: consumer in ID of a load in EX; a flush cancels it
    always_comb begin
        stall_o = id_valid & ex_valid & ex_memread & (ex_wb_addr != '0) &
                  ((id_rs_used & (ex_wb_addr == id_rs_addr)) |
                   (id_rt_used & (ex_wb_addr == id_rt_addr))) & ~flush;
    end

    assign bubble_c = flush | stall_o;

    // EX pipeline register: bubble on flush/stall/empty ID, else capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid      <= 1'b0;
            ex_alu_a      <= '0;
            ex_alu_b      <= '0;
            ex_alufun     <= '0;
            ex_sign       <= 1'b0;
            ex_store_data <= '0;
            ex_regwrite   <= 1'b0;
            ex_memread    <= 1'b0;
            ex_memwrite   <= 1'b0;
            ex_memtoreg   <= 1'b0;
            ex_wb_addr    <= '0;
        end else if (bubble_c || !id_valid) begin
            ex_valid      <= 1'b0;
            ex_alu_a      <= '0;
            ex_alu_b      <= '0;
            ex_alufun     <= '0;
            ex_sign       <= 1'b0;
            ex_store_data <= '0;
            ex_regwrite   <= 1'b0;
            ex_memread    <= 1'b0;
            ex_memwrite   <= 1'b0;
            ex_memtoreg   <= 1'b0;
            ex_wb_addr    <= '0;
        end else begin
            ex_valid      <= 1'b1;
            ex_alu_a      <= alu_a_c;
            ex_alu_b      <= alu_b_c;
            ex_alufun     <= id_alufun;
            ex_sign       <= id_sign;
            ex_store_data <= rt_fwd;
            ex_regwrite   <= id_regwrite;
            ex_memread    <= id_memread;
            ex_memwrite   <= id_memwrite;
            ex_memtoreg   <= id_memtoreg;
            ex_wb_addr    <= id_wb_addr;
        end
    end

    // Saturating count of bubbles caused by flush or load-use stall
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            bubble_cnt <= '0;
        else if (bubble_c && (bubble_cnt != {CNTW{1'b1}}))
            bubble_cnt <= bubble_cnt + CNTW'(1);
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: forwarding priority, ALUSrc, load-use
// stall, flush, r0 handling, async reset and counter saturation.
module tb_id_ex_stage;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          id_valid;
    logic [AW-1:0] id_rs_addr, id_rt_addr;
    logic          id_rs_used, id_rt_used;
    logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]    id_shamt;
    logic          id_alusrc1, id_alusrc2;
    logic [5:0]    id_alufun;
    logic          id_sign, id_regwrite, id_memread, id_memwrite, id_memtoreg;
    logic [AW-1:0] id_wb_addr;
    logic [DW-1:0] ex_fwd_data;
    logic          mem_regwrite;
    logic [AW-1:0] mem_wb_addr;
    logic [DW-1:0] mem_fwd_data;
    logic          wb_regwrite;
    logic [AW-1:0] wb_wb_addr;
    logic [DW-1:0] wb_fwd_data;
    logic          flush;

    logic          stall_o, ex_valid, ex_sign;
    logic [DW-1:0] ex_alu_a, ex_alu_b, ex_store_data;
    logic [5:0]    ex_alufun;
    logic          ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;
    logic [AW-1:0] ex_wb_addr;
    logic [15:0]   bubble_cnt;

    logic          u2_stall_o, u2_ex_valid, u2_ex_sign;
    logic [DW-1:0] u2_ex_alu_a, u2_ex_alu_b, u2_ex_store_data;
    logic [5:0]    u2_ex_alufun;
    logic          u2_ex_regwrite, u2_ex_memread, u2_ex_memwrite, u2_ex_memtoreg;
    logic [AW-1:0] u2_ex_wb_addr;
    logic [1:0]    u2_bubble_cnt;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DW(DW), .AW(AW), .CNTW(16)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_shamt(id_shamt),
        .id_alusrc1(id_alusrc1), .id_alusrc2(id_alusrc2),
        .id_alufun(id_alufun), .id_sign(id_sign),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
        .id_wb_addr(id_wb_addr), .ex_fwd_data(ex_fwd_data),
        .mem_regwrite(mem_regwrite), .mem_wb_addr(mem_wb_addr),
        .mem_fwd_data(mem_fwd_data), .wb_regwrite(wb_regwrite),
        .wb_wb_addr(wb_wb_addr), .wb_fwd_data(wb_fwd_data),
        .flush(flush), .stall_o(stall_o), .ex_valid(ex_valid),
        .ex_alu_a(ex_alu_a), .ex_alu_b(ex_alu_b), .ex_alufun(ex_alufun),
        .ex_sign(ex_sign), .ex_store_data(ex_store_data),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
        .ex_wb_addr(ex_wb_addr), .bubble_cnt(bubble_cnt)
    );

    // Narrow-counter instance sharing all stimulus, for saturation
    id_ex_stage #(.DW(DW), .AW(AW), .CNTW(2)) dut2 (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_shamt(id_shamt),
        .id_alusrc1(id_alusrc1), .id_alusrc2(id_alusrc2),
        .id_alufun(id_alufun), .id_sign(id_sign),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
        .id_wb_addr(id_wb_addr), .ex_fwd_data(ex_fwd_data),
        .mem_regwrite(mem_regwrite), .mem_wb_addr(mem_wb_addr),
        .mem_fwd_data(mem_fwd_data), .wb_regwrite(wb_regwrite),
        .wb_wb_addr(wb_wb_addr), .wb_fwd_data(wb_fwd_data),
        .flush(flush), .stall_o(u2_stall_o), .ex_valid(u2_ex_valid),
        .ex_alu_a(u2_ex_alu_a), .ex_alu_b(u2_ex_alu_b), .ex_alufun(u2_ex_alufun),
        .ex_sign(u2_ex_sign), .ex_store_data(u2_ex_store_data),
        .ex_regwrite(u2_ex_regwrite), .ex_memread(u2_ex_memread),
        .ex_memwrite(u2_ex_memwrite), .ex_memtoreg(u2_ex_memtoreg),
        .ex_wb_addr(u2_ex_wb_addr), .bubble_cnt(u2_bubble_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs sampled 1 ns after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rs_addr = '0; id_rt_addr = '0;
        id_rs_used = 0; id_rt_used = 0; id_rs_data = '0; id_rt_data = '0;
        id_imm = '0; id_shamt = '0; id_alusrc1 = 0; id_alusrc2 = 0;
        id_alufun = '0; id_sign = 0; id_regwrite = 0; id_memread = 0;
        id_memwrite = 0; id_memtoreg = 0; id_wb_addr = '0;
        ex_fwd_data = '0; mem_regwrite = 0; mem_wb_addr = '0; mem_fwd_data = '0;
        wb_regwrite = 0; wb_wb_addr = '0; wb_fwd_data = '0; flush = 0;
    endtask

    // Plain R-type reading rs/rt and writing wd
    task automatic rtype(input logic [AW-1:0] rs, input logic [DW-1:0] rsd,
                         input logic [AW-1:0] rt, input logic [DW-1:0] rtd,
                         input logic [AW-1:0] wd, input logic wr);
        idle();
        id_valid = 1; id_rs_addr = rs; id_rt_addr = rt;
        id_rs_used = 1; id_rt_used = 1; id_rs_data = rsd; id_rt_data = rtd;
        id_regwrite = wr; id_wb_addr = wd;
    endtask

    // lw into rd with base r0
    task automatic load(input logic [AW-1:0] rd);
        idle();
        id_valid = 1; id_rs_used = 1; id_alusrc2 = 1; id_imm = 32'h100;
        id_regwrite = 1; id_memread = 1; id_memtoreg = 1; id_wb_addr = rd;
    endtask

    initial begin
        // Reset with random inputs
        reset = 1;
        idle();
        id_valid = 1; id_rs_addr = AW'($urandom); id_rt_addr = AW'($urandom);
        id_rs_used = 1; id_rt_used = 1; id_rs_data = $urandom; id_rt_data = $urandom;
        id_imm = $urandom; id_alufun = 6'($urandom); id_regwrite = 1; id_memread = 1;
        mem_regwrite = 1; mem_fwd_data = $urandom; ex_fwd_data = $urandom;
        step(); step();
        check("rst_valid",  32'(ex_valid), 0);
        check("rst_data",   ex_alu_a | ex_alu_b | ex_store_data, 0);
        check("rst_ctrl",   32'({ex_alufun, ex_sign, ex_regwrite, ex_memread,
                                 ex_memwrite, ex_memtoreg, ex_wb_addr}), 0);
        check("rst_cnt",    32'(bubble_cnt), 0);
        check("rst_stall",  32'(stall_o), 0);
        check("rst_u2",     32'(|{u2_stall_o, u2_ex_valid, u2_ex_sign, u2_ex_alu_a,
                                  u2_ex_alu_b, u2_ex_store_data, u2_ex_alufun,
                                  u2_ex_regwrite, u2_ex_memread, u2_ex_memwrite,
                                  u2_ex_memtoreg, u2_ex_wb_addr, u2_bubble_cnt}), 0);
        reset = 0;

        // add r3 = r1 + r2
        rtype(5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 1);
        step();
        check("add_a",      ex_alu_a, 32'd5);
        check("add_b",      ex_alu_b, 32'd7);
        check("add_fun",    32'(ex_alufun), 0);
        check("add_valid",  32'(ex_valid), 1);
        check("add_wb",     32'({ex_regwrite, ex_wb_addr}), 32'h23);

        // Forwarding priority on rs=r4
        rtype(5'd9, 32'd0, 5'd0, 32'd0, 5'd4, 1);
        step();
        rtype(5'd4, 32'h99, 5'd0, 32'd0, 5'd0, 0);
        ex_fwd_data = 32'h11;
        mem_regwrite = 1; mem_wb_addr = 5'd4; mem_fwd_data = 32'h22;
        wb_regwrite = 1; wb_wb_addr = 5'd4; wb_fwd_data = 32'h33;
        step();
        check("fwd_ex",     ex_alu_a, 32'h11);
        step();
        check("fwd_mem",    ex_alu_a, 32'h22);
        mem_regwrite = 0;
        step();
        check("fwd_wb",     ex_alu_a, 32'h33);
        wb_regwrite = 0;
        step();
        check("fwd_rf",     ex_alu_a, 32'h99);

        // Load-use on rt=r8
        load(5'd8);
        step();
        rtype(5'd1, 32'd5, 5'd8, 32'hBAD, 5'd10, 1);
        id_rs_used = 0;
        #1;
        check("lu_stall",   32'(stall_o), 1);
        step();
        check("lu_bubble",  32'(ex_valid), 0);
        check("lu_bub_b",   ex_alu_b, 0);
        check("lu_cnt1",    32'(bubble_cnt), 1);
        check("lu_nostall", 32'(stall_o), 0);
        mem_regwrite = 1; mem_wb_addr = 5'd8; mem_fwd_data = 32'hDEAD;
        step();
        check("lu_fwd_b",   ex_alu_b, 32'hDEAD);
        check("lu_store",   ex_store_data, 32'hDEAD);
        check("lu_valid",   32'(ex_valid), 1);
        check("lu_cnt",     32'(bubble_cnt), 1);

        // Flush during load-use
        load(5'd9);
        step();
        rtype(5'd9, 32'h1, 5'd0, 32'd0, 5'd11, 1);
        flush = 1;
        #1;
        check("fl_stall",   32'(stall_o), 0);
        step();
        check("fl_valid",   32'(ex_valid), 0);
        check("fl_cnt",     32'(bubble_cnt), 2);

        // r0 never forwards
        rtype(5'd0, 32'h77, 5'd0, 32'h66, 5'd0, 0);
        mem_regwrite = 1; mem_wb_addr = 5'd0; mem_fwd_data = 32'h5;
        step();
        check("r0_a",       ex_alu_a, 0);
        check("r0_store",   ex_store_data, 0);

        // sll with shamt=31
        rtype(5'd0, 32'd0, 5'd2, 32'h40, 5'd5, 1);
        id_alusrc1 = 1; id_shamt = 5'd31; id_alufun = 6'b100000; id_sign = 1;
        step();
        check("sll_a",      ex_alu_a, 32'h1F);
        check("sll_b",      ex_alu_b, 32'h40);
        check("sll_fun",    32'(ex_alufun), 32'h20);
        check("sll_sign",   32'(ex_sign), 1);

        // Immediate B operand
        rtype(5'd1, 32'd3, 5'd2, 32'h55, 5'd6, 1);
        id_alusrc2 = 1; id_imm = 32'hFFFF_FFF0; id_memwrite = 1;
        step();
        check("imm_b",      ex_alu_b, 32'hFFFF_FFF0);
        check("imm_store",  ex_store_data, 32'h55);
        check("imm_memw",   32'(ex_memwrite), 1);

        // Empty ID slot: bubble without counting
        idle();
        id_regwrite = 1; id_wb_addr = 5'd7;
        step();
        check("nv_valid",   32'(ex_valid), 0);
        check("nv_ctrl",    32'({ex_regwrite, ex_wb_addr}), 0);
        check("nv_cnt",     32'(bubble_cnt), 2);

        // Five consecutive flushes: narrow counter saturates at 3
        idle();
        flush = 1;
        for (int i = 0; i < 5; i++) step();
        flush = 0;
        check("sat_cnt16",  32'(bubble_cnt), 7);
        check("sat_cnt2",   32'(u2_bubble_cnt), 3);

        // Async reset mid-stall
        load(5'd12);
        step();
        rtype(5'd12, 32'd0, 5'd0, 32'd0, 5'd13, 1);
        #1;
        check("mr_stall",   32'(stall_o), 1);
        #1 reset = 1;
        #1;
        check("mr_valid",   32'(ex_valid), 0);
        check("mr_nostall", 32'(stall_o), 0);
        check("mr_cnt",     32'(bubble_cnt), 0);
        step();
        reset = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
